// File: rtl/pendulum_sample_master_if.sv
// -----------------------------------------------------------------------------
// pendulum_sample_master_if
//   Handshake/operand bus between the plant-side sample sequencer and the
//   encrypted inverted-pendulum controller.
//
//   Signals:
//     start            1       one-cycle launch pulse to the controller
//     theta, alpha     DATA_W  latched sensor operands
//     theta_setpoint   DATA_W  latched setpoint operand
//     alpha_setpoint   DATA_W  latched setpoint operand
//     done             1       controller result strobe
//     control_input    DATA_W  controller result word
//
//   Modports:
//     master  the sequencer (drives start and operands, receives result)
//     slave   the controller (receives start and operands, drives result)
// -----------------------------------------------------------------------------
interface pendulum_sample_master_if #(
  parameter int DATA_W = 32
);

  logic              start;
  logic [DATA_W-1:0] theta;
  logic [DATA_W-1:0] alpha;
  logic [DATA_W-1:0] theta_setpoint;
  logic [DATA_W-1:0] alpha_setpoint;
  logic              done;
  logic [DATA_W-1:0] control_input;

  modport master (
    output start, theta, alpha, theta_setpoint, alpha_setpoint,
    input  done, control_input
  );

  modport slave (
    input  start, theta, alpha, theta_setpoint, alpha_setpoint,
    output done, control_input
  );

endinterface

// File: rtl/pendulum_sample_master.sv
// -----------------------------------------------------------------------------
// pendulum_sample_master
//   Plant-side sequencer for the encrypted inverted-pendulum controller.
//   A free-running period counter produces one tick every SAMPLE_PERIOD
//   cycles. On a tick in IDLE the live sensor/setpoint words are latched and a
//   control job is launched; the returned control word is captured and shown
//   to the actuator with a one-cycle valid pulse. A tick that lands while a
//   job is in flight is dropped and flagged (overrun); a controller that does
//   not answer within TIMEOUT WAIT cycles is abandoned and flagged
//   (timeout_err).
//
//   Ports:
//     clk           in   system clock, rising edge
//     rst           in   synchronous active-high reset
//     enable        in   runs the period counter (held at 0 when low)
//     clr_err       in   clears the sticky error flags
//     theta_in      in   DATA_W live sensor word
//     alpha_in      in   DATA_W live sensor word
//     theta_sp_in   in   DATA_W live setpoint word
//     alpha_sp_in   in   DATA_W live setpoint word
//     ctrl          bus  controller handshake (master modport)
//     u_out         out  DATA_W last captured control word
//     u_valid       out  one-cycle pulse when u_out updates
//     busy          out  high in LAUNCH and WAIT
//     overrun       out  sticky: tick arrived while busy
//     timeout_err   out  sticky: WAIT expired without done
//     sample_count  out  16-bit count of completed jobs (wraps)
//
//   Parameters: SAMPLE_PERIOD >= 4, 2 <= TIMEOUT < SAMPLE_PERIOD.
// -----------------------------------------------------------------------------
module pendulum_sample_master #(
  parameter int DATA_W        = 32,
  parameter int SAMPLE_PERIOD = 4500,
  parameter int TIMEOUT       = 4000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      clr_err,
  input  logic [DATA_W-1:0]         theta_in,
  input  logic [DATA_W-1:0]         alpha_in,
  input  logic [DATA_W-1:0]         theta_sp_in,
  input  logic [DATA_W-1:0]         alpha_sp_in,
  pendulum_sample_master_if.master  ctrl,
  output logic [DATA_W-1:0]         u_out,
  output logic                      u_valid,
  output logic                      busy,
  output logic                      overrun,
  output logic                      timeout_err,
  output logic [15:0]               sample_count
);

  localparam int PER_W  = $clog2(SAMPLE_PERIOD);
  localparam int WAIT_W = $clog2(TIMEOUT);

  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;

  logic [1:0]        state_q,        state_d;
  logic [PER_W-1:0]  per_cnt_q,      per_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q,     wait_cnt_d;
  logic [DATA_W-1:0] theta_q,        theta_d;
  logic [DATA_W-1:0] alpha_q,        alpha_d;
  logic [DATA_W-1:0] theta_sp_q,     theta_sp_d;
  logic [DATA_W-1:0] alpha_sp_q,     alpha_sp_d;
  logic [DATA_W-1:0] u_out_q,        u_out_d;
  logic              u_valid_q,      u_valid_d;
  logic              start_q,        start_d;
  logic              busy_q,         busy_d;
  logic              overrun_q,      overrun_d;
  logic              timeout_err_q,  timeout_err_d;
  logic [15:0]       sample_count_q, sample_count_d;

  logic tick;

  assign tick = enable && (per_cnt_q == PER_LAST);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    theta_d        = theta_q;
    alpha_d        = alpha_q;
    theta_sp_d     = theta_sp_q;
    alpha_sp_d     = alpha_sp_q;
    u_out_d        = u_out_q;
    u_valid_d      = 1'b0;
    sample_count_d = sample_count_q;
    // Clear first; any set event below overrides it in the same cycle.
    overrun_d      = clr_err ? 1'b0 : overrun_q;
    timeout_err_d  = clr_err ? 1'b0 : timeout_err_q;

    if (!enable) begin
      per_cnt_d = '0;
    end else if (per_cnt_q == PER_LAST) begin
      per_cnt_d = '0;
    end else begin
      per_cnt_d = per_cnt_q + PER_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          theta_d    = theta_in;
          alpha_d    = alpha_in;
          theta_sp_d = theta_sp_in;
          alpha_sp_d = alpha_sp_in;
          state_d    = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
        if (tick) overrun_d = 1'b1;
      end

      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        // done has priority over an expiring timeout in the same cycle.
        if (ctrl.done) begin
          u_out_d        = ctrl.control_input;
          u_valid_d      = 1'b1;
          sample_count_d = sample_count_q + 16'd1;
          state_d        = S_IDLE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout_err_d  = 1'b1;
          state_d        = S_IDLE;
        end
        // The tick itself is dropped; only the flag records it.
        if (tick) overrun_d = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // start and busy are registered copies of the next state so they line up
    // exactly with the LAUNCH / LAUNCH+WAIT cycles.
    start_d = (state_d == S_LAUNCH);
    busy_d  = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      per_cnt_q      <= '0;
      wait_cnt_q     <= '0;
      theta_q        <= '0;
      alpha_q        <= '0;
      theta_sp_q     <= '0;
      alpha_sp_q     <= '0;
      u_out_q        <= '0;
      u_valid_q      <= 1'b0;
      start_q        <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
      timeout_err_q  <= 1'b0;
      sample_count_q <= '0;
    end else begin
      state_q        <= state_d;
      per_cnt_q      <= per_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      theta_q        <= theta_d;
      alpha_q        <= alpha_d;
      theta_sp_q     <= theta_sp_d;
      alpha_sp_q     <= alpha_sp_d;
      u_out_q        <= u_out_d;
      u_valid_q      <= u_valid_d;
      start_q        <= start_d;
      busy_q         <= busy_d;
      overrun_q      <= overrun_d;
      timeout_err_q  <= timeout_err_d;
      sample_count_q <= sample_count_d;
    end
  end

  assign ctrl.start          = start_q;
  assign ctrl.theta          = theta_q;
  assign ctrl.alpha          = alpha_q;
  assign ctrl.theta_setpoint = theta_sp_q;
  assign ctrl.alpha_setpoint = alpha_sp_q;

  assign u_out        = u_out_q;
  assign u_valid      = u_valid_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;
  assign timeout_err  = timeout_err_q;
  assign sample_count = sample_count_q;

endmodule

// File: tb/tb_pendulum_sample_master.sv
// -----------------------------------------------------------------------------
// tb_pendulum_sample_master
//   Directed bench for pendulum_sample_master with SAMPLE_PERIOD=8. Instance
//   u_dut uses TIMEOUT=5; instance u_dut2 uses TIMEOUT=7 so a slow controller
//   can still be in WAIT when the next tick lands. Inputs are driven and
//   outputs observed on the falling edge.
// -----------------------------------------------------------------------------
module tb_pendulum_sample_master;

  localparam int DW  = 32;
  localparam int SP  = 8;
  localparam int TO  = 5;
  localparam int TO2 = 7;

  localparam logic [4*DW-1:0] OPS_ZERO = '0;
  localparam logic [4*DW-1:0] OPS_A    = {32'd20015, 32'd20017, 32'd210008, 32'd0};
  localparam logic [4*DW-1:0] OPS_B    = {32'd20004, 32'd20005, 32'd210001, 32'd2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, enable, enable2, clr_err;
  logic [DW-1:0] theta_in, alpha_in, theta_sp_in, alpha_sp_in;

  logic [DW-1:0] u_out, u_out2;
  logic          u_valid, busy, overrun, timeout_err;
  logic          u_valid2, busy2, overrun2, timeout_err2;
  logic [15:0]   sample_count, sample_count2;

  int total = 0;
  int bad   = 0;

  pendulum_sample_master_if #(.DATA_W(DW)) bus1 ();
  pendulum_sample_master_if #(.DATA_W(DW)) bus2 ();

  pendulum_sample_master #(.DATA_W(DW), .SAMPLE_PERIOD(SP), .TIMEOUT(TO)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .clr_err      (clr_err),
    .theta_in     (theta_in),
    .alpha_in     (alpha_in),
    .theta_sp_in  (theta_sp_in),
    .alpha_sp_in  (alpha_sp_in),
    .ctrl         (bus1),
    .u_out        (u_out),
    .u_valid      (u_valid),
    .busy         (busy),
    .overrun      (overrun),
    .timeout_err  (timeout_err),
    .sample_count (sample_count)
  );

  pendulum_sample_master #(.DATA_W(DW), .SAMPLE_PERIOD(SP), .TIMEOUT(TO2)) u_dut2 (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable2),
    .clr_err      (clr_err),
    .theta_in     (theta_in),
    .alpha_in     (alpha_in),
    .theta_sp_in  (theta_sp_in),
    .alpha_sp_in  (alpha_sp_in),
    .ctrl         (bus2),
    .u_out        (u_out2),
    .u_valid      (u_valid2),
    .busy         (busy2),
    .overrun      (overrun2),
    .timeout_err  (timeout_err2),
    .sample_count (sample_count2)
  );

  logic [4*DW-1:0] ops;
  assign ops = {bus1.theta, bus1.alpha, bus1.theta_setpoint, bus1.alpha_setpoint};

  // Bounded wait for the next start pulse of u_dut; n is the number of
  // falling edges consumed.
  task automatic wait_start(input int max_cycles, output int n, output bit found);
    n = 0;
    found = 1'b0;
    while (!found && n < max_cycles) begin
      @(negedge clk);
      n++;
      if (bus1.start === 1'b1) found = 1'b1;
    end
  endtask

  task automatic set_inputs(input logic [4*DW-1:0] v);
    {theta_in, alpha_in, theta_sp_in, alpha_sp_in} = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({bus1.start, busy, u_valid, overrun, timeout_err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=00000",
               {bus1.start, busy, u_valid, overrun, timeout_err});
    end
    total++;
    if (ops !== OPS_ZERO) begin
      bad++;
      $display("FAIL reset_operands got=%h want=%h", ops, OPS_ZERO);
    end
    total++;
    if (u_out !== 32'd0 || sample_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_result got u_out=%h count=%0d want 0/0", u_out, sample_count);
    end
  endtask

  task automatic test_nominal();
    int n;
    bit found;
    set_inputs(OPS_A);
    enable = 1'b1;
    wait_start(12, n, found);
    total++;
    if (!found || n != 8) begin
      bad++;
      $display("FAIL nominal_start_latency got=%0d found=%0b want=8", n, found);
    end
    total++;
    if (ops !== OPS_A || busy !== 1'b1) begin
      bad++;
      $display("FAIL nominal_operands got=%h busy=%b want=%h busy=1", ops, busy, OPS_A);
    end
    @(negedge clk);
    total++;
    if (bus1.start !== 1'b0) begin
      bad++;
      $display("FAIL nominal_start_width got=%b want=0", bus1.start);
    end
    repeat (2) @(negedge clk);
    total++;
    if (u_valid !== 1'b0) begin
      bad++;
      $display("FAIL nominal_early_valid got=%b want=0", u_valid);
    end
    bus1.done = 1'b1;
    bus1.control_input = 32'h1234;
    @(negedge clk);
    bus1.done = 1'b0;
    bus1.control_input = 32'h0;
    total++;
    if (u_valid !== 1'b1 || u_out !== 32'h1234 || sample_count !== 16'd1) begin
      bad++;
      $display("FAIL nominal_result got v=%b u=%h cnt=%0d want v=1 u=1234 cnt=1",
               u_valid, u_out, sample_count);
    end
    @(negedge clk);
    total++;
    if (u_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL nominal_after got v=%b busy=%b want 0/0", u_valid, busy);
    end
  endtask

  task automatic test_operand_hold();
    int n;
    int drift;
    bit found;
    wait_start(12, n, found);
    total++;
    if (!found || n != 3 || ops !== OPS_A) begin
      bad++;
      $display("FAIL hold_second_start got n=%0d found=%0b ops=%h want n=3 ops=%h",
               n, found, ops, OPS_A);
    end
    @(negedge clk);
    set_inputs(OPS_B);
    bus1.done = 1'b1;
    bus1.control_input = 32'h55AA;
    @(negedge clk);
    bus1.done = 1'b0;
    total++;
    if (u_valid !== 1'b1 || u_out !== 32'h55AA || sample_count !== 16'd2) begin
      bad++;
      $display("FAIL hold_first_done got v=%b u=%h cnt=%0d want v=1 u=55aa cnt=2",
               u_valid, u_out, sample_count);
    end
    n = 0;
    found = 1'b0;
    drift = (ops !== OPS_A) ? 1 : 0;
    while (!found && n < 12) begin
      @(negedge clk);
      n++;
      if (bus1.start === 1'b1) found = 1'b1;
      else if (ops !== OPS_A) drift++;
    end
    total++;
    if (drift != 0) begin
      bad++;
      $display("FAIL hold_stable got drift_cycles=%0d want 0", drift);
    end
    total++;
    if (!found || n != 6 || ops !== OPS_B) begin
      bad++;
      $display("FAIL hold_new_operands got n=%0d ops=%h want n=6 ops=%h", n, ops, OPS_B);
    end
  endtask

  // Entered on the start cycle of a job that will never be answered.
  task automatic test_timeout();
    int n;
    bit found;
    bit uv_seen;
    uv_seen = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (u_valid === 1'b1) uv_seen = 1'b1;
    end
    total++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL timeout_early got err=%b busy=%b want 0/1", timeout_err, busy);
    end
    @(negedge clk);
    if (u_valid === 1'b1) uv_seen = 1'b1;
    total++;
    if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout_flag got err=%b busy=%b want 1/0", timeout_err, busy);
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    if (u_valid === 1'b1) uv_seen = 1'b1;
    total++;
    if (timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL timeout_clear got err=%b want 0", timeout_err);
    end
    total++;
    if (uv_seen !== 1'b0 || sample_count !== 16'd2) begin
      bad++;
      $display("FAIL timeout_no_result got uv_seen=%b cnt=%0d want 0/2", uv_seen, sample_count);
    end
    wait_start(4, n, found);
    total++;
    if (!found || n != 1) begin
      bad++;
      $display("FAIL timeout_relaunch got n=%0d found=%0b want 1", n, found);
    end
  endtask

  // Entered on a start cycle; done arrives in the WAIT cycle with wait_cnt=4.
  task automatic test_coincident();
    repeat (5) @(negedge clk);
    total++;
    if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL coinc_pre got busy=%b err=%b want 1/0", busy, timeout_err);
    end
    bus1.done = 1'b1;
    bus1.control_input = 32'hBEEF;
    @(negedge clk);
    bus1.done = 1'b0;
    total++;
    if (u_valid !== 1'b1 || u_out !== 32'hBEEF || sample_count !== 16'd3 || timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL coinc_result got v=%b u=%h cnt=%0d err=%b want v=1 u=beef cnt=3 err=0",
               u_valid, u_out, sample_count, timeout_err);
    end
    @(negedge clk);
    total++;
    if (timeout_err !== 1'b0 || u_valid !== 1'b0) begin
      bad++;
      $display("FAIL coinc_after got err=%b v=%b want 0/0", timeout_err, u_valid);
    end
  endtask

  task automatic test_reset_mid_wait();
    int n;
    bit found;
    wait_start(4, n, found);
    total++;
    if (!found || n != 1) begin
      bad++;
      $display("FAIL rstmid_launch got n=%0d found=%0b want 1", n, found);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({bus1.start, busy, u_valid, overrun, timeout_err} !== 5'b0 || ops !== OPS_ZERO ||
        u_out !== 32'd0 || sample_count !== 16'd0) begin
      bad++;
      $display("FAIL rstmid_clear got flags=%b ops=%h u=%h cnt=%0d want all 0",
               {bus1.start, busy, u_valid, overrun, timeout_err}, ops, u_out, sample_count);
    end
    bus1.done = 1'b1;
    bus1.control_input = 32'hDEAD;
    @(negedge clk);
    bus1.done = 1'b0;
    total++;
    if (u_valid !== 1'b0 || sample_count !== 16'd0 || u_out !== 32'd0) begin
      bad++;
      $display("FAIL rstmid_done_ignored got v=%b cnt=%0d u=%h want 0/0/0",
               u_valid, sample_count, u_out);
    end
    wait_start(12, n, found);
    total++;
    if (!found || n != 7) begin
      bad++;
      $display("FAIL rstmid_next_start got=%0d found=%0b want 7 (8 after release)", n + 1, found);
    end
  endtask

  task automatic test_overrun();
    int n;
    int starts;
    int last_k;
    bit found;
    bit uv_seen;
    enable2 = 1'b1;
    n = 0;
    found = 1'b0;
    while (!found && n < 12) begin
      @(negedge clk);
      n++;
      if (bus2.start === 1'b1) found = 1'b1;
    end
    total++;
    if (!found || n != 8) begin
      bad++;
      $display("FAIL overrun_first_start got=%0d found=%0b want 8", n, found);
    end
    starts = 0;
    last_k = 0;
    uv_seen = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (bus2.start === 1'b1) begin
        starts++;
        last_k = k;
      end
      if (u_valid2 === 1'b1) uv_seen = 1'b1;
      if (k == 8) begin
        total++;
        if (overrun2 !== 1'b1 || timeout_err2 !== 1'b1) begin
          bad++;
          $display("FAIL overrun_flag got ovr=%b to=%b want 1/1", overrun2, timeout_err2);
        end
      end
      if (k == 9) begin
        bus2.done = 1'b1;
        bus2.control_input = 32'hCAFE;
      end
      if (k == 10) begin
        bus2.done = 1'b0;
        clr_err = 1'b1;
      end
      if (k == 11) begin
        clr_err = 1'b0;
        total++;
        if (overrun2 !== 1'b0) begin
          bad++;
          $display("FAIL overrun_clear got=%b want 0", overrun2);
        end
      end
    end
    total++;
    if (starts != 1 || last_k != 16) begin
      bad++;
      $display("FAIL overrun_single_start got starts=%0d at=%0d want 1 at 16", starts, last_k);
    end
    total++;
    if (uv_seen !== 1'b0 || sample_count2 !== 16'd0) begin
      bad++;
      $display("FAIL overrun_late_done got uv_seen=%b cnt=%0d want 0/0", uv_seen, sample_count2);
    end
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    enable2 = 1'b0;
    clr_err = 1'b0;
    set_inputs(OPS_ZERO);
    bus1.done = 1'b0;
    bus1.control_input = '0;
    bus2.done = 1'b0;
    bus2.control_input = '0;

    test_reset();
    test_nominal();
    test_operand_hold();
    test_timeout();
    test_coincident();
    test_reset_mid_wait();
    test_overrun();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
